imm_extender_pipe: RTL and testbench

- Parametrised, pipelined successor to the decode-stage immediate extender.
- Takes the 25-bit instruction field (instr[31:7]) plus a format code and produces an XLEN-wide extended immediate. Adds a CSR zero-extended immediate format and an illegal-format flag.
- Registered output behind a valid/ready handshake with a 2-entry skid buffer, so decode can stall without losing immediates; FLUSH supports branch redirect.
- Sits between instruction fetch/decode latch and the execute-stage operand mux.

---
 rtl/imm_extender_pipe.sv | 161 ++++++++++++++++
 tb/tb_imm_extender_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_extender_pipe.sv
// ============================================================================
// imm_extender_pipe : pipelined immediate extender, 2-entry skid buffer output
// Rev 1.0 : first release (XLEN 32/64, CSR uimm format, illegal-format flag)
// ============================================================================
`default_nettype none

module imm_extender_pipe #(
   parameter int         XLEN      = 32,
   parameter int         TAG_W     = 32,
   parameter logic [2:0] R_FORMAT  = 3'b000,
   parameter logic [2:0] I_FORMAT  = 3'b001,
   parameter logic [2:0] S_FORMAT  = 3'b010,
   parameter logic [2:0] U_FORMAT  = 3'b011,
   parameter logic [2:0] SB_FORMAT = 3'b100,
   parameter logic [2:0] UJ_FORMAT = 3'b101,
   parameter logic [2:0] Z_FORMAT  = 3'b110
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [24:0]      IMM_INPUT,
   input  logic [2:0]       IMM_FORMAT,
   input  logic [TAG_W-1:0] IN_TAG,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [XLEN-1:0]  IMM_OUTPUT,
   output logic [TAG_W-1:0] OUT_TAG,
   output logic             FORMAT_ERR
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic             w_s;
   logic [31:0]      w_imm32;
   logic             w_err;
   logic [XLEN-1:0]  w_ext;
   logic             w_accept;
   logic             w_deliver;
   logic [1:0]       w_state;

   logic             oreg_vld_q, oreg_vld_d;
   logic [XLEN-1:0]  oreg_imm_q, oreg_imm_d;
   logic [TAG_W-1:0] oreg_tag_q, oreg_tag_d;
   logic             oreg_err_q, oreg_err_d;
   logic             sreg_vld_q, sreg_vld_d;
   logic [XLEN-1:0]  sreg_imm_q, sreg_imm_d;
   logic [TAG_W-1:0] sreg_tag_q, sreg_tag_d;
   logic             sreg_err_q, sreg_err_d;

   assign w_s = IMM_INPUT[24];

   // Every format is built as a 32-bit value whose bit 31 already carries the
   // right sign, so widening to XLEN is a single sign extension from bit 31.
   always_comb begin
      w_imm32 = '0;
      w_err   = 1'b0;
      case (IMM_FORMAT)
         R_FORMAT:  w_imm32 = '0;
         I_FORMAT:  w_imm32 = {{20{w_s}}, IMM_INPUT[24:13]};
         S_FORMAT:  w_imm32 = {{20{w_s}}, IMM_INPUT[24:18], IMM_INPUT[4:0]};
         U_FORMAT:  w_imm32 = {IMM_INPUT[24:5], 12'b0};
         SB_FORMAT: w_imm32 = {{19{w_s}}, IMM_INPUT[24], IMM_INPUT[0],
                               IMM_INPUT[23:18], IMM_INPUT[4:1], 1'b0};
         UJ_FORMAT: w_imm32 = {{11{w_s}}, IMM_INPUT[24], IMM_INPUT[12:5],
                               IMM_INPUT[13], IMM_INPUT[23:14], 1'b0};
         Z_FORMAT:  w_imm32 = {27'b0, IMM_INPUT[12:8]};
         default:   w_err   = 1'b1;
      endcase
   end

   assign w_ext = XLEN'($signed(w_imm32));

   assign IN_READY  = !sreg_vld_q;
   assign w_accept  = IN_VALID && !sreg_vld_q;
   assign w_deliver = oreg_vld_q && OUT_READY;

   always_comb begin
      if (sreg_vld_q)      w_state = ST_FULL;
      else if (oreg_vld_q) w_state = ST_ONE;
      else                 w_state = ST_EMPTY;
   end

   always_comb begin
      oreg_vld_d = oreg_vld_q;
      oreg_imm_d = oreg_imm_q;
      oreg_tag_d = oreg_tag_q;
      oreg_err_d = oreg_err_q;
      sreg_vld_d = sreg_vld_q;
      sreg_imm_d = sreg_imm_q;
      sreg_tag_d = sreg_tag_q;
      sreg_err_d = sreg_err_q;
      if (FLUSH) begin
         oreg_vld_d = 1'b0;
         sreg_vld_d = 1'b0;
      end else begin
         case (w_state)
            ST_EMPTY, ST_ONE: begin
               if (w_accept && (w_state == ST_EMPTY || w_deliver)) begin
                  oreg_vld_d = 1'b1;
                  oreg_imm_d = w_ext;
                  oreg_tag_d = IN_TAG;
                  oreg_err_d = w_err;
               end else if (w_accept) begin
                  sreg_vld_d = 1'b1;
                  sreg_imm_d = w_ext;
                  sreg_tag_d = IN_TAG;
                  sreg_err_d = w_err;
               end else if (w_deliver) begin
                  oreg_vld_d = 1'b0;
               end
            end
            ST_FULL: begin
               if (w_deliver) begin
                  oreg_imm_d = sreg_imm_q;
                  oreg_tag_d = sreg_tag_q;
                  oreg_err_d = sreg_err_q;
                  sreg_vld_d = 1'b0;
               end
            end
            default: begin
               oreg_vld_d = 1'b0;
               sreg_vld_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         oreg_vld_q <= 1'b0;
         oreg_imm_q <= '0;
         oreg_tag_q <= '0;
         oreg_err_q <= 1'b0;
         sreg_vld_q <= 1'b0;
         sreg_imm_q <= '0;
         sreg_tag_q <= '0;
         sreg_err_q <= 1'b0;
      end else begin
         oreg_vld_q <= oreg_vld_d;
         oreg_imm_q <= oreg_imm_d;
         oreg_tag_q <= oreg_tag_d;
         oreg_err_q <= oreg_err_d;
         sreg_vld_q <= sreg_vld_d;
         sreg_imm_q <= sreg_imm_d;
         sreg_tag_q <= sreg_tag_d;
         sreg_err_q <= sreg_err_d;
      end
   end

   assign OUT_VALID  = oreg_vld_q;
   assign IMM_OUTPUT = oreg_imm_q;
   assign OUT_TAG    = oreg_tag_q;
   assign FORMAT_ERR = oreg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_extender_pipe.sv
// ============================================================================
// tb_imm_extender_pipe : XLEN=32 and XLEN=64 instances against a queue model
// ============================================================================
`default_nettype none

module tb_imm_extender_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [24:0] imm_in;
   logic [2:0]  fmt;
   logic [31:0] in_tag;

   logic        in_ready32, out_valid32, err32;
   logic [31:0] imm32, tag32;
   logic        in_ready64, out_valid64, err64;
   logic [63:0] imm64;
   logic [31:0] tag64;

   always #5 clk = ~clk;

   imm_extender_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
      .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready32),
      .IMM_INPUT(imm_in), .IMM_FORMAT(fmt), .IN_TAG(in_tag), .OUT_VALID(out_valid32),
      .OUT_READY(out_ready), .IMM_OUTPUT(imm32), .OUT_TAG(tag32), .FORMAT_ERR(err32)
   );

   imm_extender_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
      .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready64),
      .IMM_INPUT(imm_in), .IMM_FORMAT(fmt), .IN_TAG(in_tag), .OUT_VALID(out_valid64),
      .OUT_READY(out_ready), .IMM_OUTPUT(imm64), .OUT_TAG(tag64), .FORMAT_ERR(err64)
   );

   typedef struct packed {
      logic [63:0] imm;
      logic [31:0] tag;
      logic        err;
   } ent_t;

   ent_t q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic longint sx(input longint raw, input int bits);
      longint half;
      half = longint'(1) << (bits - 1);
      return (raw >= half) ? raw - (half * 2) : raw;
   endfunction

   // Immediate value as a signed integer, rebuilt from the field positions.
   function automatic logic [63:0] ref_ext(input logic [2:0] f, input logic [24:0] b);
      longint v;
      case (f)
         3'd1: v = sx(longint'(b[24:13]), 12);
         3'd2: v = sx(longint'(b[24:18]) * 32 + longint'(b[4:0]), 12);
         3'd3: v = sx(longint'(b[24:5]) * 4096, 32);
         3'd4: v = sx(longint'(b[24]) * 4096 + longint'(b[0]) * 2048
                      + longint'(b[23:18]) * 32 + longint'(b[4:1]) * 2, 13);
         3'd5: v = sx(longint'(b[24]) * 1048576 + longint'(b[12:5]) * 4096
                      + longint'(b[13]) * 2048 + longint'(b[23:14]) * 2, 21);
         3'd6: v = longint'(b[12:8]);
         default: v = 0;
      endcase
      return 64'(v);
   endfunction

   task automatic check_outputs();
      chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
      chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
      chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
      chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
      if (q.size() > 0) begin
         chk("imm32", {32'b0, imm32}, {32'b0, q[0].imm[31:0]});
         chk("imm64", imm64, q[0].imm);
         chk("tag32", 64'(tag32), 64'(q[0].tag));
         chk("tag64", 64'(tag64), 64'(q[0].tag));
         chk("err32", 64'(err32), 64'(q[0].err));
         chk("err64", 64'(err64), 64'(q[0].err));
      end
   endtask

   // One clock: model follows the edge, outputs checked on the falling edge.
   task automatic step();
      bit acc, del;
      acc = in_valid && (q.size() < 2);
      del = out_ready && (q.size() > 0);
      @(posedge clk);
      if (flush) begin
         q.delete();
      end else begin
         if (del) void'(q.pop_front());
         if (acc) q.push_back('{ref_ext(fmt, imm_in), in_tag, (fmt == 3'b111)});
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic offer(input logic [2:0] f, input logic [24:0] b, input logic [31:0] t);
      fmt      = f;
      imm_in   = b;
      in_tag   = t;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      imm_in = '0; fmt = '0; in_tag = '0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid32), 64'd0);
      chk("rst_imm32", {32'b0, imm32}, 64'd0);
      chk("rst_imm64", imm64, 64'd0);
      chk("rst_tag", 64'(tag32), 64'd0);
      chk("rst_err", 64'(err64), 64'd0);
      chk("rst_in_ready", 64'(in_ready32), 64'd1);
      rst = 1'b0;
      @(negedge clk);

      // Reference encodings
      out_ready = 1'b1;
      offer(3'b001, 25'h1FFE001, 32'h100);
      chk("addi_imm32", {32'b0, imm32}, 64'h0000_0000_FFFF_FFFF);
      chk("addi_err", 64'(err32), 64'd0);
      offer(3'b011, 25'h1000001, 32'h104);
      chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
      chk("lui_imm32", {32'b0, imm32}, 64'h0000_0000_8000_0000);
      offer(3'b100, 25'h1FC001D, 32'h108);
      chk("beq_imm32", {32'b0, imm32}, 64'h0000_0000_FFFF_FFFC);
      offer(3'b110, 25'h1001F00, 32'h10C);
      chk("csr_imm64", imm64, 64'h0000_0000_0000_001F);
      offer(3'b111, 25'h1FFFFFF, 32'h110);
      chk("bad_imm64", imm64, 64'd0);
      chk("bad_err", 64'(err64), 64'd1);
      step();

      // Backpressure: A, B taken, C held upstream, then drained in order
      out_ready = 1'b0;
      offer(3'b001, 25'h0123456, 32'hA);
      offer(3'b010, 25'h1ABCDEF, 32'hB);
      chk("bp_in_ready", 64'(in_ready32), 64'd0);
      fmt = 3'b101; imm_in = 25'h0F0F0F0; in_tag = 32'hC; in_valid = 1'b1;
      step();
      chk("bp_hold_tag", 64'(tag32), 64'hA);
      out_ready = 1'b1;
      step();
      chk("bp_tag_b", 64'(tag64), 64'hB);
      step();
      chk("bp_tag_c", 64'(tag32), 64'hC);
      in_valid = 1'b0;
      step();
      chk("bp_drained", 64'(out_valid32), 64'd0);

      // Flush while full, with an entry being offered
      out_ready = 1'b0;
      offer(3'b001, 25'h0000123, 32'hD1);
      offer(3'b001, 25'h0000456, 32'hD2);
      in_valid = 1'b1; flush = 1'b1; in_tag = 32'hD3;
      step();
      chk("flush_out_valid", 64'(out_valid64), 64'd0);
      chk("flush_in_ready", 64'(in_ready64), 64'd1);
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) step();

      // Asynchronous reset between edges while one entry is held
      out_ready = 1'b0;
      offer(3'b001, 25'h1FFE001, 32'hE1);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid32), 64'd0);
      chk("arst_imm32", {32'b0, imm32}, 64'd0);
      chk("arst_imm64", imm64, 64'd0);
      q.delete();
      #1 rst = 1'b0;
      out_ready = 1'b1;
      offer(3'b010, 25'h0A5A5A5, 32'hE2);
      chk("arst_resume_tag", 64'(tag32), 64'hE2);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 24) == 0);
         fmt       = 3'($urandom_range(0, 7));
         imm_in    = 25'($urandom);
         in_tag    = $urandom;
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
